om_blend_eqn_pipe: RTL and testbench
====================================

Name: om_blend_eqn_pipe

Overview:
- Output-merger blend-equation stage, directly downstream of the per-channel blend factor generator.
- Takes the src/dst colors and the src/dst factor colors produced upstream, and computes per channel: src*sf OP dst*df. Products are normalised to 8 bits.
- 3-stage elastic pipeline with valid/ready handshake. Result feeds the framebuffer write-back stage.

Parameters:
- TAG_WIDTH, 8, width of opaque sideband tag (pixel/request id) carried alongside each request.

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- valid_in  in  1  request valid
- ready_in  out  1  stage can accept request
- mode_rgb  in  3  blend mode for channels 0..2
- mode_a  in  3  blend mode for channel 3 (alpha)
- src_color  in  32  om_color_t source, argb packed ({a,r,g,b}, byte 3 = alpha)
- dst_color  in  32  om_color_t destination
- src_factor  in  32  om_color_t source factor (from blend factor stage)
- dst_factor  in  32  om_color_t destination factor
- tag_in  in  TAG_WIDTH  sideband
- valid_out  out  1  result valid
- ready_out  in  1  downstream accepts
- color_out  out  32  om_color_t blended color
- tag_out  out  TAG_WIDTH  sideband, matches request

Behaviour:
- Clocking/reset: single clock. reset_n asynchronous, active-low. While reset_n is low: all stage valids = 0, color_out = 0, tag_out = 0. Datapath registers also clear to 0.
- Handshake: global stall. stall = valid_out & ~ready_out. ready_in = ~stall (combinational). A stage advances when ~stall; bubbles also advance. Accept = valid_in & ready_in. Transfer = valid_out & ready_out.
- Data hold: color_out/tag_out hold stable while valid_out=1 and ready_out=0. valid_in arriving during stall is not captured; upstream holds.
- Latency/throughput: 3 cycles from accept to valid_out with no stall. Throughput 1/cycle.
- Stage 1 (multiply), per channel i=0..3, unsigned 8x8 -> 16:
  - ps[i] = src[i]*sf[i]
  - pd[i] = dst[i]*df[i]
  - Raw src[i]/dst[i] are registered for MIN/MAX.
- Stage 2 (normalise): n(p) = (p + 128 + ((p + 128) >> 8)) >> 8. This is an exact round(p/255), 8-bit result (255*255 -> 255, 255*128 -> 128, 0 -> 0). Intermediates are 17 bits, no overflow.
- Stage 3 (combine), per channel; channels 0..2 use mode_rgb, channel 3 uses mode_a, with s = n(ps), d = n(pd):
  - ADD=0: min(s+d, 255); 9-bit sum, saturate.
  - SUB=1: s>=d ? s-d : 0.
  - REV_SUB=2: d>=s ? d-s : 0.
  - MIN=3: min(src, dst), raw colors, factors ignored.
  - MAX=4: max(src, dst), raw colors.
  - 5..7 (reserved): output raw src channel (defined, not X).
- Mode flow: modes are captured at stage 1 and flow with the data. Mode changes between consecutive requests must not affect in-flight data.
- Simultaneous events: transfer and accept in the same cycle are legal. A full pipe with ready_out=1 sustains 1/cycle.
- Reset mid-operation: in-flight requests are discarded. No output until a new accept plus 3 cycles.

Decomposition:
- VX_om_pkg:
  - om_color_t (shared with factor stage).
  - Blend mode constants VX_OM_BLEND_MODE_ADD/SUB/REV_SUB/MIN/MAX.
  - VX_OM_BLEND_MODE_BITS = 3.
- Sub-module om_blend_eqn_chan: one channel's normalise + combine. Combinational, with parameter-free mode input. Instantiated 4x, with pipeline registers in the parent.
- Stall/valid control stays in the parent.

Test Plan:
- ADD, full factors: src=0x80FF4020, dst=0x40102030, sf=0xFFFFFFFF, df=0xFFFFFFFF, both modes ADD -> color_out=0xC0FF6050 exactly 3 cycles after accept.
- Normalise rounding: src=0xFFFFFFFF, sf=0x80808080, df=0 (dst anything), ADD -> 0x80808080. Also sf=0xFFFFFFFF -> 0xFFFFFFFF.
- SUB/REV_SUB clamp: src=0x10101010, dst=0x20202020, factors 0xFF.., mode_rgb=SUB, mode_a=REV_SUB -> 0x10000000.
- MIN/MAX ignore factors: src=0x11AA33CC, dst=0x22558844, sf=df=0, mode_rgb=MAX, mode_a=MIN -> 0x11AA88CC.
- Backpressure: stream 6 requests (tags 0..5), hold ready_out=0 for 4 cycles after first valid_out:
  - ready_in=0 throughout the stall.
  - color_out/tag_out stable during the stall.
  - All 6 tags emerge in order with no loss or duplication.
- Async reset mid-stream: assert reset_n=0 between clock edges with 3 requests in flight -> valid_out=0 and color_out=0 immediately. After release, no valid_out until new accept+3.

Source files
------------

// File: rtl/om_blend_eqn_pipe_pkg.sv
// rtl/om_blend_eqn_pipe_pkg.sv - shared output-merger types and blend mode constants
package VX_om_pkg;

  localparam int VX_OM_BLEND_MODE_BITS = 3;

  localparam logic [VX_OM_BLEND_MODE_BITS-1:0] VX_OM_BLEND_MODE_ADD     = 3'd0;
  localparam logic [VX_OM_BLEND_MODE_BITS-1:0] VX_OM_BLEND_MODE_SUB     = 3'd1;
  localparam logic [VX_OM_BLEND_MODE_BITS-1:0] VX_OM_BLEND_MODE_REV_SUB = 3'd2;
  localparam logic [VX_OM_BLEND_MODE_BITS-1:0] VX_OM_BLEND_MODE_MIN     = 3'd3;
  localparam logic [VX_OM_BLEND_MODE_BITS-1:0] VX_OM_BLEND_MODE_MAX     = 3'd4;

  // argb packed, byte 3 = alpha
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } om_color_t;

endpackage

// File: rtl/om_blend_eqn_pipe_if.sv
// rtl/om_blend_eqn_pipe_if.sv - request/result handshake bundle of the blend equation stage
interface om_blend_eqn_pipe_if
  import VX_om_pkg::*;
#(
  parameter int TAG_WIDTH = 8
);
  logic                             valid_in;
  logic                             ready_in;
  logic [VX_OM_BLEND_MODE_BITS-1:0] mode_rgb;
  logic [VX_OM_BLEND_MODE_BITS-1:0] mode_a;
  om_color_t                        src_color;
  om_color_t                        dst_color;
  om_color_t                        src_factor;
  om_color_t                        dst_factor;
  logic [TAG_WIDTH-1:0]             tag_in;
  logic                             valid_out;
  logic                             ready_out;
  om_color_t                        color_out;
  logic [TAG_WIDTH-1:0]             tag_out;

  modport master (
    output valid_in, mode_rgb, mode_a, src_color, dst_color, src_factor, dst_factor, tag_in,
    output ready_out,
    input  ready_in, valid_out, color_out, tag_out
  );

  modport slave (
    input  valid_in, mode_rgb, mode_a, src_color, dst_color, src_factor, dst_factor, tag_in,
    input  ready_out,
    output ready_in, valid_out, color_out, tag_out
  );
endinterface

// File: rtl/om_blend_eqn_pipe_chan.sv
// rtl/om_blend_eqn_pipe_chan.sv - one channel: normalise products (stage 2), combine (stage 3)
module om_blend_eqn_chan
  import VX_om_pkg::*;
(
  input  logic [15:0]                      i_ps,
  input  logic [15:0]                      i_pd,
  output logic [7:0]                       o_s,
  output logic [7:0]                       o_d,
  input  logic [7:0]                       i_s,
  input  logic [7:0]                       i_d,
  input  logic [7:0]                       i_src,
  input  logic [7:0]                       i_dst,
  input  logic [VX_OM_BLEND_MODE_BITS-1:0] i_mode,
  output logic [7:0]                       o_res
);
  logic [16:0] w_ts;
  logic [16:0] w_td;
  logic [16:0] w_us;
  logic [16:0] w_ud;
  logic [8:0]  w_sum;

  // (p + 128 + ((p + 128) >> 8)) >> 8 is exact round(p/255); bit 16 never sets for 8x8 products
  assign w_ts = {1'b0, i_ps} + 17'd128;
  assign w_td = {1'b0, i_pd} + 17'd128;
  assign w_us = w_ts + {8'd0, w_ts[16:8]};
  assign w_ud = w_td + {8'd0, w_td[16:8]};
  assign o_s  = w_us[16] ? 8'hFF : w_us[15:8];
  assign o_d  = w_ud[16] ? 8'hFF : w_ud[15:8];

  assign w_sum = {1'b0, i_s} + {1'b0, i_d};

  always_comb begin
    o_res = i_src;
    case (i_mode)
      VX_OM_BLEND_MODE_ADD:     o_res = w_sum[8] ? 8'hFF : w_sum[7:0];
      VX_OM_BLEND_MODE_SUB:     o_res = (i_s >= i_d) ? (i_s - i_d) : 8'h00;
      VX_OM_BLEND_MODE_REV_SUB: o_res = (i_d >= i_s) ? (i_d - i_s) : 8'h00;
      VX_OM_BLEND_MODE_MIN:     o_res = (i_src < i_dst) ? i_src : i_dst;
      VX_OM_BLEND_MODE_MAX:     o_res = (i_src > i_dst) ? i_src : i_dst;
      default:                  o_res = i_src;
    endcase
  end
endmodule

// File: rtl/om_blend_eqn_pipe.sv
// rtl/om_blend_eqn_pipe.sv - 3-stage elastic blend equation pipe: multiply, normalise, combine
module om_blend_eqn_pipe
  import VX_om_pkg::*;
#(
  parameter int TAG_WIDTH = 8
)(
  input  logic                clk,
  input  logic                reset_n,
  om_blend_eqn_pipe_if.slave  bus
);
  logic        w_stall;
  logic        w_adv;
  logic [31:0] w_src;
  logic [31:0] w_dst;
  logic [31:0] w_sf;
  logic [31:0] w_df;

  logic                             r_v1, r_v2, r_v3;
  logic [3:0][15:0]                 r_ps1, r_pd1;
  logic [31:0]                      r_src1, r_dst1, r_src2, r_dst2;
  logic [VX_OM_BLEND_MODE_BITS-1:0] r_mrgb1, r_ma1, r_mrgb2, r_ma2;
  logic [TAG_WIDTH-1:0]             r_tag1, r_tag2, r_tag3;
  logic [3:0][7:0]                  r_s2, r_d2;
  logic [31:0]                      r_color3;

  logic [3:0][7:0]                  w_s, w_d, w_res;
  logic [3:0][VX_OM_BLEND_MODE_BITS-1:0] w_mode;

  // global stall: every stage, bubbles included, freezes while the output is blocked
  assign w_stall      = r_v3 & ~bus.ready_out;
  assign w_adv        = ~w_stall;
  assign bus.ready_in = w_adv;

  assign w_src = bus.src_color;
  assign w_dst = bus.dst_color;
  assign w_sf  = bus.src_factor;
  assign w_df  = bus.dst_factor;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1    <= 1'b0;
      r_ps1   <= '0;
      r_pd1   <= '0;
      r_src1  <= '0;
      r_dst1  <= '0;
      r_mrgb1 <= '0;
      r_ma1   <= '0;
      r_tag1  <= '0;
    end else if (w_adv) begin
      r_v1    <= bus.valid_in;
      r_src1  <= w_src;
      r_dst1  <= w_dst;
      r_mrgb1 <= bus.mode_rgb;
      r_ma1   <= bus.mode_a;
      r_tag1  <= bus.tag_in;
      for (int i = 0; i < 4; i++) begin
        r_ps1[i] <= {8'd0, w_src[8*i +: 8]} * {8'd0, w_sf[8*i +: 8]};
        r_pd1[i] <= {8'd0, w_dst[8*i +: 8]} * {8'd0, w_df[8*i +: 8]};
      end
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_chan
    assign w_mode[i] = (i == 3) ? r_ma2 : r_mrgb2;

    om_blend_eqn_chan u_chan (
      .i_ps   (r_ps1[i]),
      .i_pd   (r_pd1[i]),
      .o_s    (w_s[i]),
      .o_d    (w_d[i]),
      .i_s    (r_s2[i]),
      .i_d    (r_d2[i]),
      .i_src  (r_src2[8*i +: 8]),
      .i_dst  (r_dst2[8*i +: 8]),
      .i_mode (w_mode[i]),
      .o_res  (w_res[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v2    <= 1'b0;
      r_s2    <= '0;
      r_d2    <= '0;
      r_src2  <= '0;
      r_dst2  <= '0;
      r_mrgb2 <= '0;
      r_ma2   <= '0;
      r_tag2  <= '0;
    end else if (w_adv) begin
      r_v2    <= r_v1;
      r_s2    <= w_s;
      r_d2    <= w_d;
      r_src2  <= r_src1;
      r_dst2  <= r_dst1;
      r_mrgb2 <= r_mrgb1;
      r_ma2   <= r_ma1;
      r_tag2  <= r_tag1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v3     <= 1'b0;
      r_color3 <= '0;
      r_tag3   <= '0;
    end else if (w_adv) begin
      r_v3     <= r_v2;
      r_color3 <= w_res;
      r_tag3   <= r_tag2;
    end
  end

  assign bus.valid_out = r_v3;
  assign bus.color_out = r_color3;
  assign bus.tag_out   = r_tag3;
endmodule

// File: tb/tb_om_blend_eqn_pipe.sv
// tb/tb_om_blend_eqn_pipe.sv - self-checking bench for om_blend_eqn_pipe
module tb_om_blend_eqn_pipe;
  import VX_om_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  om_blend_eqn_pipe_if #(.TAG_WIDTH(8)) bus();

  om_blend_eqn_pipe #(.TAG_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] src, dst, sf, df;
    logic [2:0]  mrgb, ma;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // round(p/255) as (2p+255)/510; p/255 never lands exactly on .5 since 255 is odd
  function automatic logic [31:0] model(input logic [31:0] s, input logic [31:0] d,
                                        input logic [31:0] sf, input logic [31:0] df,
                                        input logic [2:0] mr, input logic [2:0] ma);
    logic [31:0] res = 0;
    for (int c = 0; c < 4; c++) begin
      int a, b, fa, fb, ns, nd, r;
      logic [2:0] m;
      a  = int'((s  >> (8*c)) & 32'hFF);
      b  = int'((d  >> (8*c)) & 32'hFF);
      fa = int'((sf >> (8*c)) & 32'hFF);
      fb = int'((df >> (8*c)) & 32'hFF);
      ns = (2*a*fa + 255) / 510;
      nd = (2*b*fb + 255) / 510;
      m  = (c == 3) ? ma : mr;
      case (m)
        3'd0:    r = (ns + nd > 255) ? 255 : ns + nd;
        3'd1:    r = (ns > nd) ? ns - nd : 0;
        3'd2:    r = (nd > ns) ? nd - ns : 0;
        3'd3:    r = (a < b) ? a : b;
        3'd4:    r = (a > b) ? a : b;
        default: r = a;
      endcase
      res = res | (32'(r) << (8*c));
    end
    return res;
  endfunction

  task automatic drive(input logic [31:0] s, input logic [31:0] d, input logic [31:0] sf,
                       input logic [31:0] df, input logic [2:0] mr, input logic [2:0] ma,
                       input logic [7:0] tag);
    bus.src_color  = s;
    bus.dst_color  = d;
    bus.src_factor = sf;
    bus.dst_factor = df;
    bus.mode_rgb   = mr;
    bus.mode_a     = ma;
    bus.tag_in     = tag;
  endtask

  task automatic apply_one(input vec_t v, input logic [7:0] tag);
    @(negedge clk);
    drive(v.src, v.dst, v.sf, v.df, v.mrgb, v.ma, tag);
    bus.valid_in  = 1'b1;
    bus.ready_out = 1'b1;
    #1 check("accept_ready", bus.ready_in, 1);
    @(negedge clk);
    bus.valid_in = 1'b0;
    check("lat_edge1", bus.valid_out, 0);
    @(negedge clk);
    check("lat_edge2", bus.valid_out, 0);
    @(negedge clk);
    check("lat_edge3_valid", bus.valid_out, 1);
    check("color", bus.color_out, v.exp);
    check("tag", bus.tag_out, tag);
  endtask

  task automatic run_stream(input int n, input bit directed);
    logic [31:0] q_exp[$];
    logic [7:0]  q_tag[$];
    int sent = 0, got = 0, cyc = 0, stall_left = 0;
    bit first_seen = 0, pend = 0, prev_hold = 0;
    logic [31:0] prev_c = 0;
    logic [7:0]  prev_t = 0;
    while (got < n && cyc < 2000) begin
      @(negedge clk);
      if (!pend) begin
        if (sent < n && (directed || $urandom_range(0, 3) != 0)) begin
          drive($urandom(), $urandom(), $urandom(), $urandom(),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'(sent));
          bus.valid_in = 1'b1;
          pend = 1;
        end else begin
          bus.valid_in = 1'b0;
        end
      end
      if (directed) begin
        if (bus.valid_out && !first_seen) begin
          first_seen = 1;
          stall_left = 4;
        end
        bus.ready_out = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        bus.ready_out = 1'($urandom_range(0, 1));
      end
      #1;
      if (prev_hold) begin
        check("hold_valid", bus.valid_out, 1);
        check("hold_color", bus.color_out, prev_c);
        check("hold_tag", bus.tag_out, prev_t);
      end
      if (directed && bus.valid_out && !bus.ready_out)
        check("stall_ready_in", bus.ready_in, 0);
      if (bus.valid_out && bus.ready_out) begin
        if (q_exp.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          check("stream_color", bus.color_out, q_exp.pop_front());
          check("stream_tag", bus.tag_out, q_tag.pop_front());
        end
        got++;
      end
      if (bus.valid_in && bus.ready_in) begin
        q_exp.push_back(model(bus.src_color, bus.dst_color, bus.src_factor, bus.dst_factor,
                              bus.mode_rgb, bus.mode_a));
        q_tag.push_back(bus.tag_in);
        sent++;
        pend = 0;
      end
      prev_hold = bus.valid_out && !bus.ready_out;
      prev_c    = bus.color_out;
      prev_t    = bus.tag_out;
      cyc++;
    end
    check("stream_complete", got, n);
    check("stream_drained", q_exp.size(), 0);
    @(negedge clk);
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b1;
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{32'h80FF4020, 32'h40102030, 32'hFFFFFFFF, 32'hFFFFFFFF,
                VX_OM_BLEND_MODE_ADD, VX_OM_BLEND_MODE_ADD, 32'hC0FF6050};
    vecs[1] = '{32'hFFFFFFFF, 32'h12345678, 32'h80808080, 32'h00000000,
                VX_OM_BLEND_MODE_ADD, VX_OM_BLEND_MODE_ADD, 32'h80808080};
    vecs[2] = '{32'hFFFFFFFF, 32'h9ABCDEF0, 32'hFFFFFFFF, 32'h00000000,
                VX_OM_BLEND_MODE_ADD, VX_OM_BLEND_MODE_ADD, 32'hFFFFFFFF};
    vecs[3] = '{32'h10101010, 32'h20202020, 32'hFFFFFFFF, 32'hFFFFFFFF,
                VX_OM_BLEND_MODE_SUB, VX_OM_BLEND_MODE_REV_SUB, 32'h10000000};
    vecs[4] = '{32'h11AA33CC, 32'h22558844, 32'h00000000, 32'h00000000,
                VX_OM_BLEND_MODE_MAX, VX_OM_BLEND_MODE_MIN, 32'h11AA88CC};
    vecs[5] = '{32'h11AA33CC, 32'h22558844, 32'h5A5A5A5A, 32'hA5A5A5A5,
                3'd5, 3'd7, 32'h11AA33CC};

    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_out", bus.valid_out, 0);
    check("rst_color_out", bus.color_out, 0);
    check("rst_tag_out", bus.tag_out, 0);
    check("rst_ready_in", bus.ready_in, 1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) apply_one(vecs[i], 8'(8'h40 + i));

    run_stream(6, 1'b1);
    run_stream(60, 1'b0);

    // three requests in flight, then reset between edges
    bus.ready_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(vecs[i].src, vecs[i].dst, vecs[i].sf, vecs[i].df, vecs[i].mrgb, vecs[i].ma, 8'(i + 1));
      bus.valid_in = 1'b1;
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    #1 check("pre_rst_valid", bus.valid_out, 1);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_valid", bus.valid_out, 0);
    check("async_rst_color", bus.color_out, 0);
    check("async_rst_tag", bus.tag_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle", bus.valid_out, 0);
    end
    v = vecs[3];
    apply_one(v, 8'h77);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
